// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: function codes,
// condition-code bit positions and mem-stage states.
package pipe_pkg;

  localparam logic [3:0] FN_LDD = 4'b0001;
  localparam logic [3:0] FN_STD = 4'b0010;
  localparam logic [3:0] FN_ADD = 4'b0011;
  localparam logic [3:0] FN_NOT = 4'b0100;
  localparam logic [3:0] FN_NOP = 4'b0101;

  localparam int CCR_C = 2;
  localparam int CCR_N = 1;
  localparam int CCR_Z = 0;

  typedef enum logic {
    ST_IDLE,
    ST_MEM_WAIT
  } mem_state_t;

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory access sequencer: req/ack handshake
// plus the address, data, direction and rdst latches.
module mem_access_fsm
  import pipe_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int RDST_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              start_we,
  input  logic [DATA_W-1:0] start_addr,
  input  logic [DATA_W-1:0] start_wdata,
  input  logic [RDST_W-1:0] start_rdst,
  input  logic              mem_ack,
  output logic              idle,
  output logic              done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [RDST_W-1:0] rdst
);

  mem_state_t state, state_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    idle      = 1'b0;
    done      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        idle = 1'b1;
        if (start) state_nxt = ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        // ack only counts while a request is outstanding
        done = mem_ack;
        if (mem_ack) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdst      <= '0;
    end else if (start && idle) begin
      mem_req  <= 1'b1;
      mem_we   <= start_we;
      mem_addr <= start_addr;
      rdst     <= start_rdst;
      if (start_we) mem_wdata <= start_wdata;
    end else if (done) begin
      mem_req <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: issues LDD/STD, passes ALU results
// to writeback and owns the condition-code register.
module mem_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int RDST_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [3:0]        ex_func,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [RDST_W-1:0] ex_rdst,
  input  logic              ex_carry,
  input  logic              ex_neg,
  input  logic              ex_zero,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              wb_valid,
  output logic              wb_en,
  output logic [RDST_W-1:0] wb_rdst,
  output logic [DATA_W-1:0] wb_data,
  output logic [2:0]        ccr
);

  logic              idle;
  logic              done;
  logic              accept;
  logic              is_mem;
  logic              is_std;
  logic              wr_alu;
  logic              upd_c;
  logic              upd_nz;
  logic [RDST_W-1:0] acc_rdst;

  assign ex_ready = idle;
  assign accept   = ex_valid && ex_ready;

  always_comb begin
    is_mem = 1'b0;
    is_std = 1'b0;
    wr_alu = 1'b0;
    upd_c  = 1'b0;
    upd_nz = 1'b0;
    case (ex_func)
      FN_LDD: is_mem = 1'b1;
      FN_STD: begin
        is_mem = 1'b1;
        is_std = 1'b1;
      end
      FN_ADD: begin
        wr_alu = 1'b1;
        upd_c  = 1'b1;
        upd_nz = 1'b1;
      end
      FN_NOT: begin
        wr_alu = 1'b1;
        upd_nz = 1'b1;
      end
      default: ;
    endcase
  end

  mem_access_fsm #(
    .DATA_W(DATA_W),
    .RDST_W(RDST_W)
  ) u_fsm (
    .clk        (clk),
    .reset      (reset),
    .start      (accept && is_mem),
    .start_we   (is_std),
    .start_addr (ex_alu_out),
    .start_wdata(ex_store_data),
    .start_rdst (ex_rdst),
    .mem_ack    (mem_ack),
    .idle       (idle),
    .done       (done),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .rdst       (acc_rdst)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid <= 1'b0;
      wb_en    <= 1'b0;
      wb_rdst  <= '0;
      wb_data  <= '0;
      ccr      <= '0;
    end else begin
      wb_valid <= 1'b0;
      if (done) begin
        wb_valid <= 1'b1;
        wb_en    <= !mem_we;
        wb_rdst  <= acc_rdst;
        if (!mem_we) wb_data <= mem_rdata;
      end else if (accept && !is_mem) begin
        // NOP and undefined codes retire without a register write
        wb_valid <= 1'b1;
        wb_en    <= wr_alu;
        wb_rdst  <= ex_rdst;
        if (wr_alu) wb_data <= ex_alu_out;
        if (upd_c) ccr[CCR_C] <= ex_carry;
        if (upd_nz) begin
          ccr[CCR_N] <= ex_neg;
          ccr[CCR_Z] <= ex_zero;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed and randomized checks of mem_stage against
// an instruction-level model of retirement and CCR.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic        ex_ready;
  logic [3:0]  ex_func;
  logic [15:0] ex_alu_out;
  logic [15:0] ex_store_data;
  logic [2:0]  ex_rdst;
  logic        ex_carry, ex_neg, ex_zero;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        wb_valid, wb_en;
  logic [2:0]  wb_rdst;
  logic [15:0] wb_data;
  logic [2:0]  ccr;

  int checks = 0;
  int errors = 0;

  logic [2:0]  ccr_m;
  logic [15:0] wdata_m;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_func(ex_func), .ex_alu_out(ex_alu_out),
    .ex_store_data(ex_store_data), .ex_rdst(ex_rdst),
    .ex_carry(ex_carry), .ex_neg(ex_neg), .ex_zero(ex_zero),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wb_valid(wb_valid), .wb_en(wb_en),
    .wb_rdst(wb_rdst), .wb_data(wb_data), .ccr(ccr)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] f, input logic [15:0] alu,
                       input logic [15:0] sd, input logic [2:0] rd,
                       input logic c, input logic n, input logic z);
    ex_valid = 1'b1;
    ex_func = f;
    ex_alu_out = alu;
    ex_store_data = sd;
    ex_rdst = rd;
    ex_carry = c;
    ex_neg = n;
    ex_zero = z;
  endtask

  // one instruction, presented while the stage is idle
  task automatic do_op(input logic [3:0] f, input logic [15:0] alu,
                       input logic [15:0] sd, input logic [2:0] rd,
                       input logic c, input logic n, input logic z,
                       input int dly, input logic [15:0] rdata);
    logic is_ldd, is_std;
    is_ldd = (f == 4'd1);
    is_std = (f == 4'd2);
    drive(f, alu, sd, rd, c, n, z);
    tick();
    ex_valid = 1'b0;
    if (is_ldd || is_std) begin
      if (is_std) wdata_m = sd;
      chk("req_start", mem_req, 1);
      chk("we", mem_we, is_std);
      chk("addr", mem_addr, alu);
      chk("wdata", mem_wdata, wdata_m);
      chk("ready_wait", ex_ready, 0);
      chk("wb_quiet", wb_valid, 0);
      for (int i = 0; i < dly; i++) begin
        tick();
        chk("req_hold", mem_req, 1);
        chk("addr_hold", mem_addr, alu);
        chk("wdata_hold", mem_wdata, wdata_m);
        chk("ready_hold", ex_ready, 0);
        chk("wb_quiet2", wb_valid, 0);
      end
      mem_ack = 1'b1;
      mem_rdata = rdata;
      #1;
      chk("ready_ackcyc", ex_ready, 0);
      tick();
      mem_ack = 1'b0;
      mem_rdata = 16'($urandom);
      chk("req_drop", mem_req, 0);
      chk("wb_mem", wb_valid, 1);
      chk("wben_mem", wb_en, is_ldd);
      if (is_ldd) begin
        chk("ld_data", wb_data, rdata);
        chk("ld_rdst", wb_rdst, rd);
      end
      chk("ccr_mem", ccr, ccr_m);
      chk("ready_back", ex_ready, 1);
    end else begin
      if (f == 4'd3) ccr_m = {c, n, z};
      if (f == 4'd4) ccr_m = {ccr_m[2], n, z};
      chk("wb_alu", wb_valid, 1);
      chk("wben_alu", wb_en, (f == 4'd3 || f == 4'd4));
      if (f == 4'd3 || f == 4'd4) begin
        chk("alu_data", wb_data, alu);
        chk("alu_rdst", wb_rdst, rd);
      end
      chk("ccr_alu", ccr, ccr_m);
      chk("ready_alu", ex_ready, 1);
    end
    tick();
    chk("wb_pulse", wb_valid, 0);
  endtask

  initial begin
    logic [3:0] f;
    int pulses;
    reset = 1'b1;
    ex_valid = 1'b0;
    ex_func = 4'd0;
    ex_alu_out = '0;
    ex_store_data = '0;
    ex_rdst = '0;
    ex_carry = 1'b0;
    ex_neg = 1'b0;
    ex_zero = 1'b0;
    mem_rdata = '0;
    mem_ack = 1'b0;
    ccr_m = '0;
    wdata_m = '0;
    tick();
    tick();
    chk("rst_req", mem_req, 0);
    chk("rst_wbv", wb_valid, 0);
    chk("rst_ccr", ccr, 0);
    chk("rst_ready", ex_ready, 1);
    chk("rst_wbdata", wb_data, 0);
    reset = 1'b0;
    tick();

    do_op(4'd3, 16'h8001, 16'h0, 3'd5, 1, 1, 0, 0, 16'h0);
    chk("add_ccr110", ccr, 3'b110);
    do_op(4'd4, 16'h0000, 16'h0, 3'd2, 0, 0, 1, 0, 16'h0);
    chk("not_ccr101", ccr, 3'b101);
    do_op(4'd1, 16'h0040, 16'h0, 3'd3, 1, 1, 1, 2, 16'hBEEF);
    chk("ldd_data", wb_data, 16'hBEEF);
    do_op(4'd2, 16'h0010, 16'h1234, 3'd1, 0, 1, 0, 0, 16'h0);
    do_op(4'd5, 16'h5555, 16'h0, 3'd7, 1, 1, 1, 0, 16'h0);
    do_op(4'd9, 16'h6666, 16'h0, 3'd6, 0, 0, 0, 0, 16'h0);

    // back-to-back ADD, LDD, ADD with ex_valid held high
    pulses = 0;
    drive(4'd3, 16'h0101, 16'h0, 3'd1, 0, 0, 0);
    tick();
    ccr_m = 3'b000;
    chk("b2b_add1", wb_valid, 1);
    chk("b2b_add1d", wb_data, 16'h0101);
    pulses += int'(wb_valid);
    drive(4'd1, 16'h0200, 16'h0, 3'd2, 0, 0, 0);
    tick();
    chk("b2b_ldreq", mem_req, 1);
    chk("b2b_nowb", wb_valid, 0);
    drive(4'd3, 16'h0303, 16'h0, 3'd3, 1, 0, 0);
    tick();
    chk("b2b_stall", ex_ready, 0);
    chk("b2b_nowb2", wb_valid, 0);
    mem_ack = 1'b1;
    mem_rdata = 16'hCAFE;
    tick();
    mem_ack = 1'b0;
    chk("b2b_ld_wb", wb_valid, 1);
    chk("b2b_ld_data", wb_data, 16'hCAFE);
    chk("b2b_ld_rdst", wb_rdst, 3'd2);
    chk("b2b_ready", ex_ready, 1);
    pulses += int'(wb_valid);
    tick();
    ex_valid = 1'b0;
    ccr_m = 3'b100;
    chk("b2b_add2", wb_valid, 1);
    chk("b2b_add2d", wb_data, 16'h0303);
    chk("b2b_add2r", wb_rdst, 3'd3);
    chk("b2b_ccr", ccr, ccr_m);
    pulses += int'(wb_valid);
    tick();
    chk("b2b_end", wb_valid, 0);
    chk("b2b_pulses", pulses, 3);

    // randomized instruction stream
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) != 0) f = 4'($urandom_range(1, 5));
      else f = 4'($urandom_range(0, 15));
      do_op(f, 16'($urandom), 16'($urandom), 3'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 3)), 16'($urandom));
    end

    // reset in the middle of an outstanding load
    drive(4'd1, 16'h0ABC, 16'h0, 3'd4, 0, 0, 0);
    tick();
    ex_valid = 1'b0;
    chk("mid_req", mem_req, 1);
    reset = 1'b1;
    #1;
    chk("arst_req", mem_req, 0);
    chk("arst_addr", mem_addr, 0);
    chk("arst_wdata", mem_wdata, 0);
    chk("arst_ccr", ccr, 0);
    chk("arst_ready", ex_ready, 1);
    chk("arst_wbdata", wb_data, 0);
    tick();
    reset = 1'b0;
    ccr_m = '0;
    wdata_m = '0;
    mem_ack = 1'b1;
    mem_rdata = 16'hDEAD;
    tick();
    mem_ack = 1'b0;
    chk("late_ack_wb", wb_valid, 0);
    chk("late_ack_req", mem_req, 0);
    chk("late_ack_rdy", ex_ready, 1);
    tick();
    chk("late_ack_wb2", wb_valid, 0);
    chk("late_ack_data", wb_data, 0);
    do_op(4'd3, 16'h00F0, 16'h0, 3'd6, 0, 1, 0, 0, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline; the consumer of the execute-stage ALU result, flags and function code. It performs data-memory reads (LDD) and writes (STD) over a req/ack handshake and stalls execute while a memory access is outstanding. It passes ALU results through to writeback and owns the condition-code register (CCR).

## Interface
- DATA_W, 16, datapath and memory address/data width
- RDST_W, 3, destination register index width
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high
- ex_valid  in  1  execute presents an instruction this cycle
- ex_ready  out  1  stage accepts; transfer on ex_valid && ex_ready
- ex_func  in  4  function code: 0001 LDD, 0010 STD, 0011 ADD, 0100 NOT, 0101 NOP
- ex_alu_out  in  DATA_W  ALU result; memory address for LDD/STD
- ex_store_data  in  DATA_W  STD write data
- ex_rdst  in  RDST_W  destination register
- ex_carry, ex_neg, ex_zero  in  1 each  ALU flags for this instruction
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 = write (STD), 0 = read (LDD)
- mem_addr  out  DATA_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  read data, valid in the mem_ack cycle
- mem_ack  in  1  one-cycle completion strobe
- wb_valid  out  1  one-cycle pulse: an instruction retired to writeback
- wb_en  out  1  register-file write enable qualifying wb_valid
- wb_rdst  out  RDST_W  writeback register
- wb_data  out  DATA_W  writeback data
- ccr  out  3  {C,N,Z}

## Operation
- FSM states: IDLE, MEM_WAIT. ex_ready = (state == IDLE).
- Accepted ADD: next cycle wb_valid=1, wb_en=1, wb_data=ex_alu_out. CCR ← {ex_carry, ex_neg, ex_zero}.
- Accepted NOT: same writeback as ADD. CCR N,Z updated; C unchanged.
- Accepted NOP or any undefined code: next cycle wb_valid=1, wb_en=0. CCR unchanged.
- Accepted LDD/STD:
  - Latch mem_addr=ex_alu_out, mem_wdata=ex_store_data (STD only; otherwise hold), mem_we, rdst. Go to MEM_WAIT with mem_req=1.
  - In MEM_WAIT, mem_req, mem_we, mem_addr and mem_wdata stay stable until mem_ack is sampled high.
  - On the ack edge: mem_req←0, state←IDLE, wb_valid←1. LDD: wb_en=1, wb_data=mem_rdata. STD: wb_en=0.
  - LDD and STD never modify CCR.
- mem_ack is ignored while mem_req=0.
- wb_valid is high for exactly one cycle per retired instruction. wb_data/wb_rdst hold their last values otherwise.
- Reset: asserted asynchronously.
  - state=IDLE; mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_en, wb_rdst, wb_data all 0; ccr=000.
  - Reset during MEM_WAIT abandons the access with no writeback. A late ack after reset is ignored.

## Timing
- ALU/NOP op accepted at edge N → wb_valid high in cycle N+1; ex_ready stays 1 (full throughput).
- Mem op accepted at edge N → mem_req high from cycle N+1. The first ack is sampleable at edge N+1, so zero-wait memory gives wb_valid in N+2.
- mem_ack sampled at edge M → wb_valid high in cycle M+1 and ex_ready=1 in cycle M+1. Minimum mem-op occupancy is 2 cycles.
- ex_ready=0 throughout MEM_WAIT, including the ack cycle. No instruction is accepted on the ack edge.
- All outputs are registered except ex_ready, which is decoded from state.

## Structure
- Shared package pipe_pkg: function-code constants (FN_LDD, FN_STD, FN_ADD, FN_NOT, FN_NOP), CCR bit indices (CCR_C=2, CCR_N=1, CCR_Z=0), mem-stage state enum.
- Sub-module mem_access_fsm: owns state, the req/ack handshake and the address/data/we latches, and exports an ack-done strobe. Top level holds the CCR and writeback registers.

## Test plan
- ADD, alu_out=16'h8001, flags C=1 N=1 Z=0, rdst=5 → next cycle wb_valid=1, wb_en=1, wb_data=8001, wb_rdst=5, ccr=110.
- NOT with prior ccr=110, alu_out=0, flags C=0 N=0 Z=1 → wb_data=0000, ccr=101 (C preserved).
- LDD addr 16'h0040, ack delayed 3 cycles with rdata=16'hBEEF → mem_req high 3 cycles then low; ex_ready low throughout; wb_data=BEEF, wb_en=1 the cycle after ack; ccr unchanged.
- STD addr 16'h0010, data 16'h1234, zero-wait ack → mem_we=1, mem_wdata=1234 held with req; wb_valid=1, wb_en=0.
- Back-to-back ADD, LDD, ADD with ex_valid held high → second ADD accepted only the cycle after the LDD ack; three wb_valid pulses in program order.
- Reset asserted mid-MEM_WAIT, then ack pulsed after release → mem_req drops immediately; all outputs 0; no wb_valid; late ack ignored.
